// File: rtl/tft_pixel_loader.sv
// UART-to-SDRAM pixel front end: parses sync/page header, packs byte pairs into RGB565
// FIFO pushes, and walks the write address one pixel per wr_done. Option: TFT_LOADER_AUTO_FLIP_EN.
module tft_pixel_loader #(
   parameter int          H_PIXELS  = 800,
   parameter int          V_LINES   = 480,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5,
   parameter int          TIMEOUT   = 5000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        fifo_full,
   output logic        fifo_wr_req,
   output logic [15:0] fifo_din,
   input  logic        wr_done,
   output logic [2:0]  page_set,
   output logic [2:0]  page_show,
   output logic [8:0]  row_add_user,
   output logic [9:0]  col_add_user,
   output logic        frame_done,
   output logic        overflow,
   output logic        timeout,
   output logic        busy
);

   localparam int              TMR_W      = $clog2(TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);
   localparam logic [18:0]     FRAME_PIX  = 19'(H_PIXELS * V_LINES);
   localparam logic [9:0]      COL_LAST   = 10'(H_PIXELS - 1);
   localparam logic [8:0]      ROW_LAST   = 9'(V_LINES - 1);

   typedef enum logic [1:0] {IDLE, PAGE, HI, LO} state_t;

   state_t             state_q;
   logic [TMR_W-1:0]   timer_q;
   logic [18:0]        pix_cnt_q;
   logic [18:0]        pix_cnt_d;
   logic [18:0]        pending_q;
   logic [18:0]        pending_d;
   logic [7:0]         hi_q;
   logic               fifo_wr_req_q;
   logic [15:0]        fifo_din_q;
   logic [2:0]         page_set_q;
   logic [2:0]         page_show_q;
   logic [8:0]         row_q;
   logic [8:0]         row_d;
   logic [9:0]         col_q;
   logic [9:0]         col_d;
   logic               frame_done_q;
   logic               overflow_q;
   logic               timeout_q;
   logic               wr_acc;
   logic               last_pix;

   // A write completion with nothing outstanding is spurious and must not move the address.
   assign wr_acc    = wr_done && (pending_q != 19'd0);
   assign last_pix  = (row_q == ROW_LAST) && (col_q == COL_LAST);
   assign pix_cnt_d = pix_cnt_q + 19'd1;

   always_comb begin
      pending_d = pending_q;
      if (fifo_wr_req_q && !wr_acc)
         pending_d = pending_q + 19'd1;
      else if (!fifo_wr_req_q && wr_acc)
         pending_d = pending_q - 19'd1;
   end

   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (wr_acc) begin
         if (col_q == COL_LAST) begin
            col_d = 10'd0;
            row_d = (row_q == ROW_LAST) ? 9'd0 : row_q + 9'd1;
         end else begin
            col_d = col_q + 10'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         timer_q       <= '0;
         pix_cnt_q     <= '0;
         pending_q     <= '0;
         hi_q          <= '0;
         fifo_wr_req_q <= 1'b0;
         fifo_din_q    <= '0;
         page_set_q    <= '0;
         page_show_q   <= '0;
         row_q         <= '0;
         col_q         <= '0;
         frame_done_q  <= 1'b0;
         overflow_q    <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         fifo_wr_req_q <= 1'b0;
         frame_done_q  <= wr_acc && last_pix;
         pending_q     <= pending_d;
         row_q         <= row_d;
         col_q         <= col_d;
`ifdef TFT_LOADER_AUTO_FLIP_EN
         // page_set cannot change while pixels are outstanding, so this is the finished page.
         if (wr_acc && last_pix)
            page_show_q <= page_set_q;
`endif
         if (rx_valid) begin
            timer_q <= '0;
            case (state_q)
               IDLE: begin
                  if (rx_data == SYNC_BYTE && pending_q == 19'd0) begin
                     state_q    <= PAGE;
                     overflow_q <= 1'b0;
                     timeout_q  <= 1'b0;
                  end
               end
               PAGE: begin
                  page_set_q <= rx_data[2:0];
`ifndef TFT_LOADER_AUTO_FLIP_EN
                  page_show_q <= rx_data[2:0];
`endif
                  row_q     <= 9'd0;
                  col_q     <= 10'd0;
                  pix_cnt_q <= 19'd0;
                  state_q   <= HI;
               end
               HI: begin
                  hi_q    <= rx_data;
                  state_q <= LO;
               end
               default: begin
                  if (!fifo_full) begin
                     fifo_wr_req_q <= 1'b1;
                     fifo_din_q    <= {hi_q, rx_data};
                     pix_cnt_q     <= pix_cnt_d;
                     state_q       <= (pix_cnt_d == FRAME_PIX) ? IDLE : HI;
                  end else begin
                     overflow_q <= 1'b1;
                     state_q    <= IDLE;
                  end
               end
            endcase
         end else if (state_q != IDLE) begin
            if (timer_q == TMR_LAST) begin
               timer_q   <= '0;
               timeout_q <= 1'b1;
               state_q   <= IDLE;
            end else begin
               timer_q <= timer_q + TMR_W'(1);
            end
         end
      end
   end

   assign fifo_wr_req  = fifo_wr_req_q;
   assign fifo_din     = fifo_din_q;
   assign page_set     = page_set_q;
   assign page_show    = page_show_q;
   assign row_add_user = row_q;
   assign col_add_user = col_q;
   assign frame_done   = frame_done_q;
   assign overflow     = overflow_q;
   assign timeout      = timeout_q;
   assign busy         = (state_q != IDLE) || (pending_q != 19'd0);

endmodule

// File: doc/tft_pixel_loader.md
Name: tft_pixel_loader

Overview:
- Write-side front end for the TFT frame store.
- Parses a UART byte stream and packs byte pairs into RGB565 pixels.
- Pushes each pixel into the SDRAM write FIFO that the display controller drains.
- Generates the write page and row/column address that the display controller uses for each SDRAM write, advancing one pixel per write-completion pulse.

Parameters:
H_PIXELS, 800, pixels per line (col wraps at H_PIXELS-1)
V_LINES, 480, lines per frame (row wraps at V_LINES-1)
SYNC_BYTE, 8'hA5, frame header sync value
TIMEOUT, 5000000, idle clk cycles between bytes before a mid-frame abort

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
rx_data  in  8  received UART byte
rx_valid  in  1  one-cycle strobe, rx_data valid
fifo_full  in  1  write FIFO cannot accept data
fifo_wr_req  out  1  one-cycle FIFO push strobe
fifo_din  out  16  pixel {hi_byte, lo_byte}
wr_done  in  1  one-cycle pulse: SDRAM accepted one pixel write
page_set  out  3  page currently being written
page_show  out  3  page to display
row_add_user  out  9  row of the next SDRAM write
col_add_user  out  10  column of the next SDRAM write
frame_done  out  1  one-cycle pulse on the last pixel's wr_done
overflow  out  1  sticky: pixel lost to fifo_full
timeout  out  1  sticky: frame aborted by byte gap
busy  out  1  state!=IDLE or pending!=0

Behaviour:
- Reset: all outputs 0; state IDLE; pending, pixel count and timer 0.
- FSM, advances only on rx_valid:
  - IDLE: a byte equal to SYNC_BYTE with pending==0 -> PAGE; clears overflow and timeout. Any other byte, or a sync while pending!=0, is ignored.
  - PAGE: page_set <= rx_data[2:0]; row and col cleared to 0; pixel count cleared -> HI.
  - HI: latch hi byte -> LO.
  - LO:
    - If fifo_full=0: on the next clk, fifo_din={hi,rx_data} and fifo_wr_req=1 for exactly one cycle (latency 1). Pixel count +1. If the count reaches H_PIXELS*V_LINES -> IDLE, else -> HI.
    - If fifo_full=1: no push; overflow<=1; -> IDLE (frame aborted).
- Timeout: in PAGE/HI/LO the timer counts clk cycles without rx_valid and resets on each rx_valid. At TIMEOUT -> IDLE and timeout<=1. Pixels already pushed are kept.
- pending (19 bits) tracks pixels pushed but not yet written:
  - +1 on fifo_wr_req; -1 on wr_done; unchanged when both occur in the same cycle.
  - wr_done with pending==0 is ignored: no address or pending change.
- Address, on each accepted wr_done:
  - col+1.
  - At col==H_PIXELS-1: col<=0, row+1.
  - At row==V_LINES-1 and col==H_PIXELS-1: both <=0 and frame_done pulses in the cycle after that wr_done.
- Addresses are updated only by wr_done or PAGE entry. A PAGE byte can only arrive with pending==0, so an address clear never races an outstanding write.
- page_show without the feature: loaded with rx_data[2:0] in PAGE, same cycle as page_set.
- A new rx_valid arriving in the same cycle as a timeout expiry: rx_valid wins (timer resets, byte processed).

Optional Feature:
- Macro: TFT_LOADER_AUTO_FLIP_EN
- Defined: page_show does not change at PAGE. It loads page_set on the cycle frame_done pulses, so the display flips only to a fully written page. Aborted frames never update page_show.
- Undefined: page_show follows the header page immediately, as described in Behaviour.

Test Plan:
1. Assert rst low mid-frame, release -> all outputs 0, state IDLE, busy=0.
2. Bytes A5,02,12,34,56,78 with fifo_full=0 -> page_set=2; fifo_wr_req pulses with fifo_din=16'h1234 then 16'h5678. Two wr_done -> col=2, row=0, pending=0.
3. H_PIXELS=4, V_LINES=2: A5,01 plus 16 bytes, then 8 wr_done -> 8 pushes; frame_done one pulse after the 8th wr_done; row=col=0. With AUTO_FLIP_EN, page_show 0->1 on that cycle; without it, page_show=1 right after the header.
4. A5,00,AB, then CD with fifo_full=1 -> no push, overflow=1, state IDLE; a following byte 11 is ignored.
5. TIMEOUT=100: A5,03,12, then 100 idle cycles -> timeout=1, IDLE; a later 34 is ignored; the next A5 clears timeout.
6. 3 pixels pushed, no wr_done, then A5 -> ignored (pending=3). After 3 wr_done, A5,04 is accepted -> row=col=0, page_set=4.
